sme_feeder: RTL and testbench

SME_FEEDER -- requirements
Module: sme_feeder

---
 rtl/sme_feeder_if.sv | 29 ++
 rtl/sme_feeder.sv | 196 +++++++++++++++++++
 tb/tb_sme_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_feeder_if.sv
// Host byte stream plus matcher character/result bus for sme_feeder.
// Latency: none, this file only groups wires.
// Backpressure: in_ready qualifies in_valid; the matcher side has no backpressure.
//
// Signals:
//   in_valid / in_data / in_ready : host byte stream, accepted when valid & ready
//   chardata / isstring / ispattern : character stream driven to the matcher
//   sme_valid / sme_match           : matcher result strobe and match flag
// Modports: slave = feeder side, master = host/matcher side.
interface sme_feeder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       sme_match;

    modport master (
        output in_valid, in_data, sme_valid, sme_match,
        input  in_ready, chardata, isstring, ispattern
    );

    modport slave (
        input  in_valid, in_data, sme_valid, sme_match,
        output in_ready, chardata, isstring, ispattern
    );
endinterface

// File: rtl/sme_feeder.sv
// Frame parser buffering string/pattern bytes and replaying them to a string matcher.
// Latency: first character one cycle after the 0x0A terminator is accepted, then one per cycle.
// Backpressure: in_ready is high only in IDLE/RX states; no stall on the matcher side.
//
// Ports: clk, reset (sync, active high), bus (sme_feeder_if.slave), busy, ovf,
//        match_cnt, and timeout when SME_FEEDER_TIMEOUT_EN is defined.
// Build option: SME_FEEDER_TIMEOUT_EN adds a 255-cycle watchdog on the result wait.
module sme_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    sme_feeder_if.slave    bus,
    output logic           busy,
    output logic           ovf,
    output logic [7:0]     match_cnt
`ifdef SME_FEEDER_TIMEOUT_EN
    ,
    output logic           timeout
`endif
);

    localparam int MAXB = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int PW   = $clog2(MAXB + 1);
    localparam int SAW  = $clog2(STR_MAX);
    localparam int PAW  = $clog2(PAT_MAX);

    localparam logic [PW-1:0] STR_LIM = PW'(STR_MAX);
    localparam logic [PW-1:0] PAT_LIM = PW'(PAT_MAX);
    localparam logic [7:0]    LF      = 8'h0A;
    localparam logic [7:0]    TYPE_S  = 8'h53;
    localparam logic [7:0]    TYPE_P  = 8'h50;

    typedef enum logic [2:0] {
        IDLE,
        RX_STR,
        RX_PAT,
        TX_STR,
        TX_PAT,
        WAIT_RES
    } state_t;

    state_t        state;
    logic [PW-1:0] wp;
    logic [PW-1:0] rd;
    logic [PW-1:0] tx_len;
    logic [7:0]    char_r;
    logic          isstr_r;
    logic          ispat_r;
    logic          ovf_r;
    logic [7:0]    match_r;
`ifdef SME_FEEDER_TIMEOUT_EN
    logic [7:0]    wd;
    logic          timeout_r;
`endif

    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];

    logic in_ready_int;
    logic accept;
    logic rx_full;
    logic str_we;
    logic pat_we;

    assign in_ready_int = (state == IDLE) || (state == RX_STR) || (state == RX_PAT);
    assign accept       = bus.in_valid && in_ready_int;
    assign rx_full      = (state == RX_STR) ? (wp == STR_LIM) : (wp == PAT_LIM);
    assign str_we       = accept && (state == RX_STR) && (bus.in_data != LF) && (wp != STR_LIM);
    assign pat_we       = accept && (state == RX_PAT) && (bus.in_data != LF) && (wp != PAT_LIM);

    // Buffers carry no reset: contents are only read below the length
    // captured from the write pointer, so stale bytes are never emitted.
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_buf[wp[SAW-1:0]] <= bus.in_data;
        end
        if (pat_we) begin
            pat_buf[wp[PAW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wp        <= '0;
            rd        <= '0;
            tx_len    <= '0;
            char_r    <= 8'h00;
            isstr_r   <= 1'b0;
            ispat_r   <= 1'b0;
            ovf_r     <= 1'b0;
            match_r   <= 8'h00;
`ifdef SME_FEEDER_TIMEOUT_EN
            wd        <= 8'h00;
            timeout_r <= 1'b0;
`endif
        end else begin
`ifdef SME_FEEDER_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_data == TYPE_S) begin
                            state <= RX_STR;
                            wp    <= '0;
                            ovf_r <= 1'b0;
                        end else if (bus.in_data == TYPE_P) begin
                            state <= RX_PAT;
                            wp    <= '0;
                            ovf_r <= 1'b0;
                        end
                    end
                end

                RX_STR, RX_PAT: begin
                    if (accept) begin
                        if (bus.in_data == LF) begin
                            if (wp == '0) begin
                                state <= IDLE;
                            end else begin
                                // Character 0 is launched on the terminator edge so it
                                // appears in the very next cycle; rd continues from 1.
                                tx_len <= wp;
                                rd     <= PW'(1);
                                if (state == RX_STR) begin
                                    state   <= TX_STR;
                                    isstr_r <= 1'b1;
                                    char_r  <= str_buf[SAW'(0)];
                                end else begin
                                    state   <= TX_PAT;
                                    ispat_r <= 1'b1;
                                    char_r  <= pat_buf[PAW'(0)];
                                end
                            end
                        end else if (rx_full) begin
                            ovf_r <= 1'b1;
                        end else begin
                            wp <= wp + PW'(1);
                        end
                    end
                end

                TX_STR, TX_PAT: begin
                    if (rd == tx_len) begin
                        isstr_r <= 1'b0;
                        ispat_r <= 1'b0;
                        char_r  <= 8'h00;
                        state   <= (state == TX_PAT) ? WAIT_RES : IDLE;
`ifdef SME_FEEDER_TIMEOUT_EN
                        wd      <= 8'h00;
`endif
                    end else begin
                        char_r <= (state == TX_STR) ? str_buf[rd[SAW-1:0]]
                                                    : pat_buf[rd[PAW-1:0]];
                        rd     <= rd + PW'(1);
                    end
                end

                WAIT_RES: begin
                    if (bus.sme_valid) begin
                        if (bus.sme_match) begin
                            match_r <= match_r + 8'd1;
                        end
                        state <= IDLE;
                    end
`ifdef SME_FEEDER_TIMEOUT_EN
                    // wd counts completed silent cycles; the 255th one ends the wait.
                    else if (wd == 8'd254) begin
                        timeout_r <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wd <= wd + 8'd1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.chardata  = char_r;
    assign bus.isstring  = isstr_r;
    assign bus.ispattern = ispat_r;
    assign busy          = (state != IDLE);
    assign ovf           = ovf_r;
    assign match_cnt     = match_r;
`ifdef SME_FEEDER_TIMEOUT_EN
    assign timeout       = timeout_r;
`endif

endmodule

// File: tb/tb_sme_feeder.sv
// Self-checking bench for sme_feeder: directed frames plus randomized frames vs a frame-level model.
// Latency: expects first character one cycle after the terminator is accepted.
// Backpressure: the host task holds each byte until in_ready is seen.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_sme_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic       ovf;
    logic [7:0] match_cnt;
`ifdef SME_FEEDER_TIMEOUT_EN
    logic       timeout;
`endif

    sme_feeder_if bus();

    sme_feeder #(.STR_MAX(32), .PAT_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .busy      (busy),
        .ovf       (ovf),
        .match_cnt (match_cnt)
`ifdef SME_FEEDER_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int bad_both = 0;
    int bad_zero = 0;

    logic [7:0] mon_dat [$];
    int         mon_cyc [$];
    bit         mon_pat [$];
    logic [7:0] fix_pl  [$];
    logic [7:0] exp_match = 8'h00;

    always #5 clk = ~clk;

    // Records every emitted character with the index of the cycle it appeared in.
    always @(negedge clk) begin
        if (bus.isstring || bus.ispattern) begin
            mon_dat.push_back(bus.chardata);
            mon_cyc.push_back(cyc);
            mon_pat.push_back(bus.ispattern);
        end
        if (bus.isstring && bus.ispattern) bad_both++;
        if (!bus.isstring && !bus.ispattern && bus.chardata != 8'h00) bad_zero++;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int tgt);
        while (cyc < tgt) tick();
    endtask

    task automatic mon_clear();
        mon_dat.delete();
        mon_cyc.delete();
        mon_pat.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) `CHK("in_ready_wait", bus.in_ready, 1'b1)
        last_acc = cyc;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    // One whole frame: type byte, n payload bytes, terminator, then the result
    // strobe d cycles into the result wait for pattern frames.
    task automatic run_frame(input bit is_pat, input int n, input int d,
                             input bit m, input bit use_fix);
        logic [7:0] pl [$];
        logic [7:0] b;
        int lf, exp_n, maxb;
        maxb  = is_pat ? 8 : 32;
        exp_n = (n > maxb) ? maxb : n;
        mon_clear();
        send(is_pat ? 8'h50 : 8'h53);
        `CHK("ovf_clear_on_type", ovf, 1'b0)
        for (int i = 0; i < n; i++) begin
            if (use_fix) b = fix_pl[i];
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0A) b = 8'h0B;
            end
            pl.push_back(b);
            send(b);
        end
        send(8'h0A);
        lf = last_acc;
        if (exp_n > 0) begin
            `CHK("in_ready_tx", bus.in_ready, 1'b0)
            `CHK("busy_tx", busy, 1'b1)
        end
        if (is_pat && exp_n > 0) begin
            // A strobe while characters are still going out must be ignored.
            bus.sme_valid = 1'b1;
            bus.sme_match = 1'b1;
            tick();
            bus.sme_valid = 1'b0;
            bus.sme_match = 1'b0;
            wait_until(lf + exp_n + 1 + d);
            `CHK("busy_wait_res", busy, 1'b1)
            bus.sme_valid = 1'b1;
            bus.sme_match = m;
            tick();
            bus.sme_valid = 1'b0;
            bus.sme_match = 1'b0;
            if (m) exp_match = exp_match + 8'd1;
        end else begin
            wait_until(lf + exp_n + 1);
        end
        `CHK("busy_end", busy, 1'b0)
        `CHK("in_ready_end", bus.in_ready, 1'b1)
        `CHK("isstring_end", bus.isstring, 1'b0)
        `CHK("ispattern_end", bus.ispattern, 1'b0)
        `CHK("match_cnt", match_cnt, exp_match)
        `CHK("ovf", ovf, (n > maxb))
        `CHK("emit_count", mon_dat.size(), exp_n)
        for (int i = 0; i < exp_n && i < mon_dat.size(); i++) begin
            `CHK("emit_data", mon_dat[i], pl[i])
            `CHK("emit_cycle", mon_cyc[i], lf + 1 + i)
            `CHK("emit_kind", mon_pat[i], is_pat)
        end
    endtask

    initial begin
        logic [7:0] jb;
        int lf;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.sme_valid = 1'b0;
        bus.sme_match = 1'b0;
        reset = 1'b1;
        repeat (3) tick();

        // Reset values
        `CHK("rst_chardata", bus.chardata, 8'h00)
        `CHK("rst_isstring", bus.isstring, 1'b0)
        `CHK("rst_ispattern", bus.ispattern, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_ovf", ovf, 1'b0)
        `CHK("rst_match_cnt", match_cnt, 8'h00)
        `CHK("rst_in_ready", bus.in_ready, 1'b1)
`ifdef SME_FEEDER_TIMEOUT_EN
        `CHK("rst_timeout", timeout, 1'b0)
`endif
        reset = 1'b0;
        tick();

        // "S","abc",LF
        fix_pl = '{8'h61, 8'h62, 8'h63};
        run_frame(1'b0, 3, 0, 1'b0, 1'b1);

        // "P","b.",LF with a matching result four cycles after the terminator
        fix_pl = '{8'h62, 8'h2E};
        run_frame(1'b1, 2, 1, 1'b1, 1'b1);

        // Pattern overflow: 10 bytes, only 8 go out; next 'S' clears ovf
        run_frame(1'b1, 10, 2, 1'b0, 1'b0);
        run_frame(1'b0, 5, 0, 1'b0, 1'b0);

        // Junk byte in IDLE, then an empty string frame
        mon_clear();
        send(8'h41);
        `CHK("junk_busy", busy, 1'b0)
        `CHK("junk_in_ready", bus.in_ready, 1'b1)
        run_frame(1'b0, 0, 0, 1'b0, 1'b0);

        // String overflow at the buffer boundary
        run_frame(1'b0, 32, 0, 1'b0, 1'b0);
        run_frame(1'b0, 34, 0, 1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            bit   is_pat;
            int   n;
            if ($urandom_range(0, 3) == 0) begin
                do jb = 8'($urandom_range(0, 255)); while (jb == 8'h53 || jb == 8'h50);
                send(jb);
                `CHK("rand_junk_busy", busy, 1'b0)
            end
            is_pat = 1'($urandom_range(0, 1));
            n = is_pat ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 35));
            run_frame(is_pat, n, int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the second string output cycle
        mon_clear();
        send(8'h53);
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        send(8'h0A);
        lf = last_acc;
        tick();
        reset = 1'b1;
        tick();
        exp_match = 8'h00;
        `CHK("mid_rst_isstring", bus.isstring, 1'b0)
        `CHK("mid_rst_ispattern", bus.ispattern, 1'b0)
        `CHK("mid_rst_chardata", bus.chardata, 8'h00)
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_ovf", ovf, 1'b0)
        `CHK("mid_rst_match_cnt", match_cnt, 8'h00)
        `CHK("mid_rst_in_ready", bus.in_ready, 1'b1)
        reset = 1'b0;
        repeat (3) tick();
        `CHK("mid_rst_emit_count", mon_dat.size(), 2)
        if (mon_cyc.size() > 0) `CHK("mid_rst_first_cycle", mon_cyc[0], lf + 1)

        // Normal operation after the abort
        run_frame(1'b1, 3, 0, 1'b1, 1'b0);

`ifdef SME_FEEDER_TIMEOUT_EN
        // Pattern with no result: watchdog ends the wait
        mon_clear();
        send(8'h50);
        send(8'h71);
        send(8'h0A);
        lf = last_acc;
        wait_until(lf + 2 + 254);
        `CHK("to_before_pulse", timeout, 1'b0)
        `CHK("to_before_busy", busy, 1'b1)
        tick();
        `CHK("to_pulse", timeout, 1'b1)
        `CHK("to_idle", busy, 1'b0)
        `CHK("to_match_cnt", match_cnt, exp_match)
        tick();
        `CHK("to_pulse_end", timeout, 1'b0)
`endif

        `CHK("both_flags_never", bad_both, 0)
        `CHK("chardata_zero_idle", bad_zero, 0)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
